// File: rtl/pc_ir_unit_if.sv
// Memory handshake bundle between pc_ir_unit (master) and a variable-latency memory (slave).
interface pc_ir_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/pc_ir_unit.sv
// Multicycle MIPS PC / IR / MDR stage turning controller strobes into a req/ack memory handshake.
// Optional PC alignment checking is enabled by defining PC_ALIGN_CHECK_EN.
module pc_ir_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             PCWrite,
    input  logic             BranchEQ,
    input  logic             BranchNE,
    input  logic             IRWrite,
    input  logic             IorD,
    input  logic             MemWrite,
    input  logic [1:0]       PCSrc,
    input  logic             Zero,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic [WIDTH-1:0] ALUOut,
    input  logic [WIDTH-1:0] WriteData,
    pc_ir_unit_if.master     mem,
    output logic             stall,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] Instr,
    output logic [WIDTH-1:0] Data,
    output logic [5:0]       opcode,
    output logic             misaligned
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_ir_sel;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [WIDTH-1:0] r_mem_addr;
    logic [WIDTH-1:0] r_mem_wdata;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_data;
    logic             r_misaligned;

    logic             w_access;
    logic             w_stall;
    logic             w_pc_en;
    logic             w_next_valid;
    logic             w_align_fault;
    logic             w_load_pc;
    logic [WIDTH-1:0] w_addr;
    logic [WIDTH-1:0] w_next_pc;

    // Access detection, stall and next-PC selection
    always_comb begin
        w_access     = IRWrite | IorD;
        w_addr       = IorD ? ALUOut : r_pc;
        w_stall      = w_access & (r_state != S_DONE);
        w_pc_en      = (PCWrite | (BranchEQ & Zero) | (BranchNE & ~Zero)) & ~w_stall;
        w_next_pc    = r_pc;
        w_next_valid = 1'b0;
        case (PCSrc)
            2'b00: begin
                w_next_pc    = ALUResult;
                w_next_valid = 1'b1;
            end
            2'b01: begin
                w_next_pc    = ALUOut;
                w_next_valid = 1'b1;
            end
            2'b10: begin
                w_next_pc    = {r_pc[WIDTH-1:28], r_instr[25:0], 2'b00};
                w_next_valid = 1'b1;
            end
            default: begin
                w_next_pc    = r_pc;
                w_next_valid = 1'b0;
            end
        endcase
`ifdef PC_ALIGN_CHECK_EN
        w_align_fault = w_pc_en & w_next_valid & (w_next_pc[1:0] != 2'b00);
`else
        w_align_fault = 1'b0;
`endif
        w_load_pc = w_pc_en & w_next_valid & ~w_align_fault;
    end

    // Memory handshake FSM with IR / MDR capture on ack
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ir_sel    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {WIDTH{1'b0}};
            r_mem_wdata <= {WIDTH{1'b0}};
            r_instr     <= {WIDTH{1'b0}};
            r_data      <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        r_mem_addr  <= w_addr;
                        r_mem_we    <= MemWrite;
                        r_mem_wdata <= WriteData;
                        r_ir_sel    <= IRWrite;
                        r_mem_req   <= 1'b1;
                        r_state     <= S_BUSY;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    // Request outputs stay frozen until the ack arrives
                    if (mem.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_DONE;
                        if (!r_mem_we) begin
                            if (r_ir_sel) begin
                                r_instr <= mem.mem_rdata;
                            end else begin
                                r_data <= mem.mem_rdata;
                            end
                        end
                    end else begin
                        r_state <= S_BUSY;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    // Program counter and sticky alignment flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_misaligned <= 1'b0;
        end else begin
            if (w_load_pc) begin
                r_pc <= w_next_pc;
            end
            r_misaligned <= r_misaligned | w_align_fault;
        end
    end

    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign stall         = w_stall;
    assign PC            = r_pc;
    assign Instr         = r_instr;
    assign Data          = r_data;
    assign opcode        = r_instr[WIDTH-1:WIDTH-6];
    assign misaligned    = r_misaligned;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed self-checking bench for pc_ir_unit: reset, fetch, load, store, branch, jump, ignored ack, alignment.
module tb_pc_ir_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        PCWrite, BranchEQ, BranchNE, IRWrite, IorD, MemWrite, Zero;
    logic [1:0]  PCSrc;
    logic [31:0] ALUResult, ALUOut, WriteData;
    logic        stall, misaligned;
    logic [31:0] PC, Instr, Data;
    logic [5:0]  opcode;

    int n_checks = 0;
    int n_pass   = 0;

    pc_ir_unit_if #(.WIDTH(32)) mem_bus ();

    pc_ir_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .reset(reset),
        .PCWrite(PCWrite), .BranchEQ(BranchEQ), .BranchNE(BranchNE),
        .IRWrite(IRWrite), .IorD(IorD), .MemWrite(MemWrite),
        .PCSrc(PCSrc), .Zero(Zero),
        .ALUResult(ALUResult), .ALUOut(ALUOut), .WriteData(WriteData),
        .mem(mem_bus.master),
        .stall(stall), .PC(PC), .Instr(Instr), .Data(Data),
        .opcode(opcode), .misaligned(misaligned)
    );

    always #5 clock = ~clock;

    task automatic clear_inputs();
        PCWrite = 1'b0; BranchEQ = 1'b0; BranchNE = 1'b0;
        IRWrite = 1'b0; IorD = 1'b0; MemWrite = 1'b0; Zero = 1'b0;
        PCSrc = 2'b00; ALUResult = 32'h0; ALUOut = 32'h0; WriteData = 32'h0;
    endtask

    // Plays the memory: acks in the delay-th BUSY cycle and counts stall cycles until DONE.
    task automatic run_access(input int delay, input logic [31:0] rdata, input logic exp_we,
                              input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                              output int stall_cyc, output int hold_bad, output logic timed_out);
        int  busy = 0;
        int  k    = 0;
        logic done = 1'b0;
        stall_cyc = 0; hold_bad = 0;
        while (!done && k < 20) begin
            @(negedge clock);
            if (stall !== 1'b1) begin
                done = 1'b1;
            end else begin
                stall_cyc++;
                @(posedge clock); #1;
                if (mem_bus.mem_req === 1'b1) begin
                    busy++;
                    if (mem_bus.mem_we !== exp_we || mem_bus.mem_addr !== exp_addr ||
                        mem_bus.mem_wdata !== exp_wdata)
                        hold_bad++;
                    mem_bus.mem_ack   = (busy == delay);
                    mem_bus.mem_rdata = rdata;
                end else begin
                    mem_bus.mem_ack = 1'b0;
                end
            end
            k++;
        end
        mem_bus.mem_ack = 1'b0;
        timed_out = ~done;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        clear_inputs();
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        chk("reset_pc", PC, 32'h0);
        chk("reset_instr", Instr, 32'h0);
        chk("reset_data", Data, 32'h0);
        chk("reset_req", {31'h0, mem_bus.mem_req}, 32'h0);
        chk("reset_we", {31'h0, mem_bus.mem_we}, 32'h0);
        chk("reset_addr", mem_bus.mem_addr, 32'h0);
        chk("reset_wdata", mem_bus.mem_wdata, 32'h0);
        chk("reset_stall", {31'h0, stall}, 32'h0);
        chk("reset_misaligned", {31'h0, misaligned}, 32'h0);
        @(negedge clock) reset = 1'b0;
    endtask

    task automatic test_fetch();
        int sc, hb; logic to;
        @(posedge clock); #1;
        IRWrite = 1'b1; PCWrite = 1'b1; PCSrc = 2'b00; ALUResult = 32'h4;
        run_access(2, 32'h8C08_0004, 1'b0, 32'h0, 32'h0, sc, hb, to);
        chk("fetch_timeout", {31'h0, to}, 32'h0);
        chk("fetch_stall_cycles", sc, 32'd3);
        chk("fetch_hold", hb, 32'd0);
        chk("fetch_instr", Instr, 32'h8C08_0004);
        chk("fetch_opcode", {26'h0, opcode}, {26'h0, 6'b100011});
        chk("fetch_req_low", {31'h0, mem_bus.mem_req}, 32'h0);
        chk("fetch_pc_before_done", PC, 32'h0);
        @(posedge clock); #1;
        chk("fetch_pc_after_done", PC, 32'h4);
        clear_inputs();
    endtask

    task automatic test_load();
        int sc, hb; logic to;
        @(posedge clock); #1;
        IorD = 1'b1; ALUOut = 32'h200;
        run_access(1, 32'h1234_5678, 1'b0, 32'h200, 32'h0, sc, hb, to);
        chk("load_timeout", {31'h0, to}, 32'h0);
        chk("load_stall_cycles", sc, 32'd2);
        chk("load_hold", hb, 32'd0);
        chk("load_data", Data, 32'h1234_5678);
        chk("load_instr_kept", Instr, 32'h8C08_0004);
        @(posedge clock); #1;
        clear_inputs();
        chk("load_pc_kept", PC, 32'h4);
    endtask

    task automatic test_ignored_ack();
        @(posedge clock); #1;
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hFFFF_FFFF;
        @(posedge clock); #1;
        mem_bus.mem_ack = 1'b0;
        chk("idle_ack_instr", Instr, 32'h8C08_0004);
        chk("idle_ack_data", Data, 32'h1234_5678);
        chk("idle_ack_req", {31'h0, mem_bus.mem_req}, 32'h0);
    endtask

    task automatic test_branch();
        @(posedge clock); #1;
        BranchEQ = 1'b1; Zero = 1'b1; PCSrc = 2'b01; ALUOut = 32'h40;
        @(negedge clock);
        chk("beq_no_stall", {31'h0, stall}, 32'h0);
        @(posedge clock); #1;
        chk("beq_taken", PC, 32'h40);
        Zero = 1'b0; ALUOut = 32'h80;
        @(posedge clock); #1;
        chk("beq_not_taken", PC, 32'h40);
        BranchEQ = 1'b0; BranchNE = 1'b1;
        @(posedge clock); #1;
        chk("bne_taken", PC, 32'h80);
        BranchEQ = 1'b1; Zero = 1'b1; ALUOut = 32'hC0;
        @(posedge clock); #1;
        chk("both_branch_eq_met", PC, 32'hC0);
        clear_inputs();
        PCWrite = 1'b1; PCSrc = 2'b11; ALUResult = 32'h100; ALUOut = 32'h100;
        @(posedge clock); #1;
        chk("pcsrc_reserved_hold", PC, 32'hC0);
        clear_inputs();
    endtask

    task automatic test_jump();
        int sc, hb; logic to;
        @(posedge clock); #1;
        PCWrite = 1'b1; PCSrc = 2'b00; ALUResult = 32'h1000_0000;
        @(posedge clock); #1;
        chk("jump_setup_pc", PC, 32'h1000_0000);
        clear_inputs();
        IRWrite = 1'b1;
        run_access(1, 32'h0800_0010, 1'b0, 32'h1000_0000, 32'h0, sc, hb, to);
        chk("jump_fetch_timeout", {31'h0, to}, 32'h0);
        chk("jump_fetch_hold", hb, 32'd0);
        @(posedge clock); #1;
        clear_inputs();
        chk("jump_instr", Instr, 32'h0800_0010);
        PCWrite = 1'b1; PCSrc = 2'b10;
        @(posedge clock); #1;
        chk("jump_pc", PC, 32'h1000_0040);
        clear_inputs();
    endtask

    task automatic test_store();
        int sc, hb; logic to;
        @(posedge clock); #1;
        IorD = 1'b1; MemWrite = 1'b1; ALUOut = 32'h100; WriteData = 32'hDEAD_BEEF;
        run_access(3, 32'h5555_AAAA, 1'b1, 32'h100, 32'hDEAD_BEEF, sc, hb, to);
        chk("store_timeout", {31'h0, to}, 32'h0);
        chk("store_stall_cycles", sc, 32'd4);
        chk("store_hold", hb, 32'd0);
        chk("store_data_kept", Data, 32'h1234_5678);
        chk("store_instr_kept", Instr, 32'h0800_0010);
        @(posedge clock); #1;
        clear_inputs();
        chk("store_pc_kept", PC, 32'h1000_0040);
    endtask

    task automatic test_align();
        @(posedge clock); #1;
        PCWrite = 1'b1; PCSrc = 2'b00; ALUResult = 32'h6;
        @(posedge clock); #1;
        clear_inputs();
`ifdef PC_ALIGN_CHECK_EN
        chk("align_pc_hold", PC, 32'h1000_0040);
        chk("align_flag", {31'h0, misaligned}, 32'h1);
`else
        chk("noalign_pc_load", PC, 32'h6);
        chk("noalign_flag", {31'h0, misaligned}, 32'h0);
`endif
    endtask

    task automatic test_reset_busy();
        @(posedge clock); #1;
        IRWrite = 1'b1;
        @(posedge clock); #1;
        chk("rbusy_req_high", {31'h0, mem_bus.mem_req}, 32'h1);
        #3;
        reset = 1'b1; IRWrite = 1'b0;
        #1;
        chk("rbusy_req_drop", {31'h0, mem_bus.mem_req}, 32'h0);
        chk("rbusy_pc", PC, 32'h0);
        chk("rbusy_stall", {31'h0, stall}, 32'h0);
        @(negedge clock) reset = 1'b0;
        @(posedge clock); #1;
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hAAAA_5555;
        @(posedge clock); #1;
        mem_bus.mem_ack = 1'b0;
        chk("rbusy_late_ack_instr", Instr, 32'h0);
        chk("rbusy_late_ack_data", Data, 32'h0);
        chk("rbusy_late_ack_req", {31'h0, mem_bus.mem_req}, 32'h0);
        chk("rbusy_misaligned_clr", {31'h0, misaligned}, 32'h0);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_load();
        test_ignored_ack();
        test_branch();
        test_jump();
        test_store();
        test_align();
        test_reset_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_ir_unit.md
# pc_ir_unit

Multicycle MIPS program-counter, instruction-register and memory-handshake stage, paired with `main_controller`. It consumes the controller's PC/branch/memory strobes and feeds it `opcode` from the instruction register. It converts the controller's single-cycle memory strobes into a req/ack handshake with variable-latency memory. A `stall` output freezes the controller while an access is outstanding.

## Interface
- `WIDTH`, 32: address/data width.
- `RESET_PC`, 32'h0000_0000: PC value on reset.

- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `PCWrite`, `BranchEQ`, `BranchNE`, `IRWrite`, `IorD`, `MemWrite`  in  1 each  controller strobes.
- `PCSrc`  in  2  next-PC select from controller.
- `Zero`  in  1  ALU zero flag.
- `ALUResult`  in  WIDTH  combinational ALU result.
- `ALUOut`  in  WIDTH  registered ALU result.
- `WriteData`  in  WIDTH  store data (B register).
- `mem_req`  out  1  memory request, registered.
- `mem_we`  out  1  write request.
- `mem_addr`  out  WIDTH  access address.
- `mem_wdata`  out  WIDTH  store data.
- `mem_ack`  in  1  one-cycle completion pulse.
- `mem_rdata`  in  WIDTH  read data, valid with `mem_ack`.
- `stall`  out  1  combinational; controller clock-enable is `~stall`.
- `PC`, `Instr`, `Data`  out  WIDTH  PC, instruction register, memory data register.
- `opcode`  out  6  `Instr[31:26]`.
- `misaligned`  out  1  sticky alignment fault (see Configuration).

## Operation
- Reset values:
  - `PC`=RESET_PC.
  - `Instr`=0, `Data`=0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `misaligned`=0.
  - FSM state is IDLE.
- Access request: `access = IRWrite | IorD`. This covers fetch, load and store.
- Address and write enable:
  - Address is `PC` when `IorD`=0, otherwise `ALUOut`.
  - `mem_we = MemWrite`.
- Memory FSM, state IDLE:
  - If `access`, latch the address, `mem_we`, `WriteData` and an `ir_sel` flag (`ir_sel = IRWrite`). Go to BUSY.
  - Otherwise stay in IDLE.
- Memory FSM, state BUSY:
  - `mem_req`=1 and all request outputs are held stable.
  - On `mem_ack` with `ir_sel`=1: `Instr <= mem_rdata`.
  - On `mem_ack` with `ir_sel`=0 and `mem_we`=0: `Data <= mem_rdata`.
  - On `mem_ack` with `mem_we`=1: no register is loaded.
  - On `mem_ack`: `mem_req` drops on that edge and the FSM goes to DONE.
- Memory FSM, state DONE: go to IDLE unconditionally. The controller advances on this edge.
- Stall: `stall = access & (state != DONE)`.
- PC enable: `pc_en = (PCWrite | (BranchEQ & Zero) | (BranchNE & ~Zero)) & ~stall`.
- Next PC by `PCSrc`:
  - 00: `ALUResult`.
  - 01: `ALUOut`.
  - 10: `{PC[31:28], Instr[25:0], 2'b00}`.
  - 11: reserved; PC holds even if `pc_en`=1.
- Both `BranchEQ` and `BranchNE` high: the PC loads if either condition is met.
- Ignored `mem_ack`: an ack in IDLE or DONE is ignored and changes no register.
- Reset mid-access: `mem_req` falls asynchronously and the FSM returns to IDLE. An ack arriving after reset is ignored.

## Timing
- Every memory access costs at least 3 cycles:
  - IDLE detect, `stall`=1.
  - BUSY with ack in the same cycle.
  - DONE, `stall`=0.
- Each extra cycle of ack delay adds 1 cycle of `stall`.
- Non-memory controller states (decode, execute, branch, jump) cost 0 stall cycles. PC updates on the same edge.
- Fetch: `Instr` updates on the ack edge. `PC` updates on the DONE-cycle edge, from `ALUResult` computed off the old `PC`.
- `opcode` is valid from the cycle after the ack edge.

## Configuration
- `PC_ALIGN_CHECK_EN`:
  - Defined: a PC load whose next-PC has bits [1:0] ≠ 0 is suppressed (PC holds) and `misaligned` is set. `misaligned` stays set until reset.
  - Undefined: the PC loads any value and `misaligned` is tied 0.

## Test plan
- Reset: assert `reset` mid-cycle → `PC`=0, `Instr`=0, `mem_req`=0 and `stall`=0 immediately, without waiting for a clock edge.
- Fetch, ack delay 2:
  - Stimulus: `IRWrite`=1, `PCWrite`=1, `PCSrc`=00, `ALUResult`=0x4, `mem_rdata`=0x8C080004.
  - Response: `stall`=1 for 3 cycles; `mem_addr`=0x0.
  - Response: `Instr`=0x8C080004 and `opcode`=100011.
  - Response: `PC`=0x4 after the DONE edge.
- Branch:
  - `BranchEQ`=1, `Zero`=1, `PCSrc`=01, `ALUOut`=0x40 → `PC`=0x40 next edge, with no stall.
  - Same with `Zero`=0 → `PC` unchanged.
  - `BranchNE`=1, `Zero`=0 → `PC`=0x40.
- Jump: `PC`=0x10000000, `Instr`=0x08000010, `PCSrc`=10, `PCWrite`=1 → `PC`=0x10000040.
- Store:
  - Stimulus: `IorD`=1, `MemWrite`=1, `ALUOut`=0x100, `WriteData`=0xDEADBEEF, ack after 3 cycles.
  - Response: `mem_we`=1, `mem_addr`=0x100 and `mem_wdata`=0xDEADBEEF, stable until ack.
  - Response: `Data` and `Instr` unchanged.
- Reset in BUSY:
  - Stimulus: raise `reset` with `mem_req`=1, then pulse `mem_ack` 1 cycle after release.
  - Response: `mem_req` falls immediately; `PC`=RESET_PC; the late ack leaves `Instr`/`Data`=0.
  - With `PC_ALIGN_CHECK_EN`: `PCWrite` with `ALUResult`=0x6 → `PC` holds and `misaligned`=1.
